// File: rtl/flash_cmd_sequencer.sv
// Command-sequence tracker for a parallel NOR flash behind the PRG ROM window.
// Decodes unlock/program/erase/autoselect cycles and models the flash busy time.
module flash_cmd_sequencer #(
  parameter logic [23:0] PROG_CYCLES         = 24'd40,
  parameter logic [23:0] SECTOR_ERASE_CYCLES = 24'd1_000_000,
  parameter logic [23:0] CHIP_ERASE_CYCLES   = 24'd16_000_000
) (
  input  logic        m2,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        prg_write_enabled,
  output logic        we_allow,
  output logic        busy,
  output logic        autoselect,
  output logic        seq_error,
  output logic [3:0]  state_code,
  output logic [15:0] prog_count
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_U1     = 4'd1,
    S_U2     = 4'd2,
    S_PROG   = 4'd3,
    S_E80    = 4'd4,
    S_EU1    = 4'd5,
    S_EU2    = 4'd6,
    S_BUSY_P = 4'd7,
    S_BUSY_E = 4'd8,
    S_ASEL   = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        wr_en;
  logic [10:0] addr_lo;
  logic        is_555, is_2aa, is_f0;
  logic        u1_match, u2_match;
  logic        bad_seq;
  logic        unused_addr_hi;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign wr_en          = wr_valid & prg_write_enabled;
  assign addr_lo        = wr_addr[10:0];
  assign unused_addr_hi = ^wr_addr[14:11];
  assign is_555         = (addr_lo == 11'h555);
  assign is_2aa         = (addr_lo == 11'h2AA);
  assign is_f0          = (wr_data == 8'hF0);
  assign u1_match       = is_555 & (wr_data == 8'hAA);
  assign u2_match       = is_2aa & (wr_data == 8'h55);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    bad_seq = 1'b0;
    case (state_q)
      // Busy states ignore the bus entirely; only the timer moves.
      S_BUSY_P, S_BUSY_E: begin
        if (timer_q == 24'd0) state_d = S_IDLE;
        else                  timer_d = timer_q - 24'd1;
      end
      S_IDLE: begin
        if (wr_en && u1_match) state_d = S_U1;
      end
      S_U1: begin
        if (wr_en) begin
          if (u2_match) state_d = S_U2;
          else          bad_seq = 1'b1;
        end
      end
      S_U2: begin
        if (wr_en) begin
          if (is_555 && wr_data == 8'hA0)      state_d = S_PROG;
          else if (is_555 && wr_data == 8'h80) state_d = S_E80;
          else if (is_555 && wr_data == 8'h90) state_d = S_ASEL;
          else                                 bad_seq = 1'b1;
        end
      end
      S_PROG: begin
        if (wr_en) begin
          state_d = S_BUSY_P;
          timer_d = PROG_CYCLES - 24'd1;
          cnt_d   = sat_inc16(cnt_q);
        end
      end
      S_E80: begin
        if (wr_en) begin
          if (u1_match) state_d = S_EU1;
          else          bad_seq = 1'b1;
        end
      end
      S_EU1: begin
        if (wr_en) begin
          if (u2_match) state_d = S_EU2;
          else          bad_seq = 1'b1;
        end
      end
      S_EU2: begin
        if (wr_en) begin
          if (is_555 && wr_data == 8'h10) begin
            state_d = S_BUSY_E;
            timer_d = CHIP_ERASE_CYCLES - 24'd1;
          end else if (wr_data == 8'h30) begin
            state_d = S_BUSY_E;
            timer_d = SECTOR_ERASE_CYCLES - 24'd1;
          end else begin
            bad_seq = 1'b1;
          end
        end
      end
      S_ASEL: begin
        if (wr_en && is_f0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // F0 is the documented reset command, so it aborts silently.
    if (bad_seq) begin
      state_d = S_IDLE;
      err_d   = ~is_f0;
    end
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= 24'd0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q == S_BUSY_P) || (state_q == S_BUSY_E);
  assign autoselect = (state_q == S_ASEL);
  assign we_allow   = prg_write_enabled & ~busy;
  assign seq_error  = err_q;
  assign state_code = state_q;
  assign prog_count = cnt_q;

endmodule

// File: doc/flash_cmd_sequencer.md
FLASH_CMD_SEQUENCER -- requirements
Module: flash_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter PROG_CYCLES, default 24'd40, which is the busy time after a program data write, in m2 cycles.
REQ-002 The block SHALL have parameter SECTOR_ERASE_CYCLES, default 24'd1_000_000, which is the busy time after a sector-erase command, in m2 cycles.
REQ-003 The block SHALL have parameter CHIP_ERASE_CYCLES, default 24'd16_000_000, which is the busy time after a chip-erase command, in m2 cycles.
REQ-004 m2  input  1  CPU M2, the only clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_valid  input  1  one-cycle pulse: the CPU wrote to ROM space ($8000-$FFFF) this cycle.
REQ-007 wr_addr  input  15  CPU address bits [14:0] of the write.
REQ-008 wr_data  input  8  CPU data of the write.
REQ-009 prg_write_enabled  input  1  mapper configuration bit; when 0, all writes are ignored.
REQ-010 we_allow  output  1  gate for flash_we: 1 means the current write may reach the flash.
REQ-011 busy  output  1  a program or erase is in progress.
REQ-012 autoselect  output  1  the flash is in ID mode.
REQ-013 seq_error  output  1  one-cycle pulse on an illegal command sequence.
REQ-014 state_code  output  4  current FSM state, encoded as in REQ-016.
REQ-015 prog_count  output  16  number of accepted program operations, saturating.

Function
REQ-016 The FSM states and their codes SHALL be: IDLE=0, U1=1, U2=2, PROG=3, E80=4, EU1=5, EU2=6, BUSY_P=7, BUSY_E=8, ASEL=9.
REQ-017 "U1 match" SHALL mean addr[10:0]==11'h555 with data 8'hAA; "U2 match" SHALL mean addr[10:0]==11'h2AA with data 8'h55.
REQ-018 The FSM SHALL evaluate transitions only on cycles with wr_valid=1 and prg_write_enabled=1; otherwise it holds, except for the BUSY timer.
REQ-019 Transitions from IDLE: on U1 match go to U1; on any other write stay in IDLE with no error.
REQ-020 Transitions from U1: on U2 match go to U2.
REQ-021 Transitions from U2, all with addr[10:0]==11'h555: data A0 goes to PROG, data 80 goes to E80, data 90 goes to ASEL.
REQ-022 Transition from PROG: any write goes to BUSY_P, loads the timer with PROG_CYCLES-1, and increments prog_count (saturating at 16'hFFFF).
REQ-023 Transition from E80: on U1 match go to EU1.
REQ-024 Transition from EU1: on U2 match go to EU2.
REQ-025 Transitions from EU2:
- data 10 at addr[10:0]==11'h555 goes to BUSY_E with timer=CHIP_ERASE_CYCLES-1;
- data 30 at any address goes to BUSY_E with timer=SECTOR_ERASE_CYCLES-1.
REQ-026 ASEL SHALL be left only by a write of data F0 (any address), which goes to IDLE.
REQ-027 In states U1, U2, E80, EU1 and EU2, a write of data F0 SHALL go to IDLE with no error.
REQ-028 In states U1, U2, E80, EU1 and EU2, any other non-matching write SHALL go to IDLE and pulse seq_error for one cycle.
REQ-029 In BUSY_P and BUSY_E, the 24-bit timer SHALL decrement every m2 cycle, and the state SHALL go to IDLE in the cycle after the timer reads 0.
REQ-030 In BUSY_P and BUSY_E, writes SHALL be ignored: no transition, no error, no count change.
REQ-031 busy SHALL be 1 exactly in BUSY_P or BUSY_E; autoselect SHALL be 1 exactly in ASEL.
REQ-032 we_allow SHALL be combinational: prg_write_enabled & ~busy.
REQ-033 we_allow SHALL be 1 during the very write that enters a BUSY state, and 0 from the next cycle on.
REQ-034 A write in PROG with prg_write_enabled=0 SHALL be ignored; the FSM stays in PROG.
REQ-035 A simultaneous timer expiry and wr_valid SHALL be handled as: go to IDLE, and the write is ignored.
REQ-036 seq_error SHALL be registered and SHALL be 0 in every cycle not named in REQ-028.

Reset
REQ-037 While reset=1 at a rising edge of m2:
- state=IDLE, timer=0, prog_count=0, seq_error=0;
- therefore busy=0, autoselect=0, state_code=0.
REQ-038 reset SHALL take priority over every transition, including from BUSY_P, BUSY_E and ASEL mid-operation.
REQ-039 After reset, we_allow SHALL equal prg_write_enabled.

Verification
REQ-040 Program sequence: with PROG_CYCLES=4, write AA@555, 55@2AA, A0@555, 3C@1234 -> state_code goes 1,2,3,7; busy=1 for exactly 4 cycles; then IDLE; prog_count=1.
REQ-041 Sector erase: with SECTOR_ERASE_CYCLES=8, write AA@555, 55@2AA, 80@555, AA@555, 55@2AA, 30@4000 -> busy=1 for 8 cycles; prog_count unchanged.
REQ-042 Illegal sequence: write AA@555, then 12@2AA -> seq_error pulses once, state_code=0; a following F0 write produces no error.
REQ-043 Autoselect: write AA@555, 55@2AA, 90@555 -> autoselect=1; writes 00@0000 and AA@555 leave state_code=9; writing F0 -> state_code=0.
REQ-044 Busy blocking and reset: during BUSY_E with timer>100, issue an A0 write -> we_allow=0, no state change; then assert reset for 1 cycle -> busy=0, prog_count=0 on the next edge.
REQ-045 Gate off: with prg_write_enabled=0, the full program sequence -> state stays 0, we_allow=0, prog_count=0.
